// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification for the sequential ALU.
package alu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_AND  = 4'd0;
    localparam logic [OPW-1:0] OP_OR   = 4'd1;
    localparam logic [OPW-1:0] OP_NOR  = 4'd2;
    localparam logic [OPW-1:0] OP_ADD  = 4'd3;
    localparam logic [OPW-1:0] OP_SUB  = 4'd4;
    localparam logic [OPW-1:0] OP_SLT  = 4'd5;
    localparam logic [OPW-1:0] OP_SLL  = 4'd6;
    localparam logic [OPW-1:0] OP_SRL  = 4'd7;
    localparam logic [OPW-1:0] OP_MUL  = 4'd8;
    localparam logic [OPW-1:0] OP_DIVU = 4'd9;
    localparam logic [OPW-1:0] OP_REMU = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // True for ops that run through the iterative multiplier/divider.
    function automatic logic is_multicycle(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// WIDTH-step shift-add multiplier / restoring divider on one 2*WIDTH accumulator.
// Result outputs show the accumulator after the current step, so they are
// final in the cycle where last is high.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_run;
    logic               r_mul;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // One multiply step (add-then-shift-right) and one restoring divide step.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
        w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                             : {1'b0, r_acc[2*WIDTH-1:1]};
        w_shl     = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff    = w_shl - {1'b0, r_b};
        w_div_nxt = w_diff[WIDTH] ? {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                  : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        w_acc_nxt = r_mul ? w_mul_nxt : w_div_nxt;
    end

    assign prod_lo    = w_acc_nxt[WIDTH-1:0];
    assign prod_hi_nz = |w_acc_nxt[2*WIDTH-1:WIDTH];
    assign quot       = w_acc_nxt[WIDTH-1:0];
    assign rem        = w_acc_nxt[2*WIDTH-1:WIDTH];
    assign last       = r_run && (r_cnt == '0);

    // Operand load and per-cycle iteration with step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
            r_mul <= 1'b0;
        end else if (load) begin
            r_mul <= (op == OP_MUL);
            r_acc <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
            r_b   <= (op == OP_MUL) ? a : b;
            r_cnt <= CW'(WIDTH - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU
// behind a start/done handshake with busy.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             ovfl,
    output logic             div0
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [OPW-1:0]   r_op;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_r;
    logic             r_zero;
    logic             r_ovfl;
    logic             r_div0;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovfl;
    logic             w_div0;
    logic             w_go_calc;
    logic             w_go_single;

    logic [WIDTH-1:0] w_prod_lo;
    logic             w_prod_hi_nz;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic             w_last;
    logic [WIDTH-1:0] w_it_res;
    logic             w_it_ovfl;

    assign w_sum       = a + b;
    assign w_diff      = a - b;
    assign w_go_calc   = (r_state == IDLE) && start && is_multicycle(op)
                         && ((op == OP_MUL) || (b != '0));
    assign w_go_single = (r_state == IDLE) && start && !w_go_calc;

    // Single-cycle result; DIVU/REMU only reach here with b == 0.
    always_comb begin
        w_res  = '0;
        w_ovfl = 1'b0;
        w_div0 = 1'b0;
        case (op)
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_NOR:  w_res = ~(a | b);
            OP_ADD: begin
                w_res  = w_sum;
                w_ovfl = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res  = w_diff;
                w_ovfl = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  w_res = WIDTH'(a < b);
            OP_SLL:  w_res = a << b[SHW-1:0];
            OP_SRL:  w_res = a >> b[SHW-1:0];
            OP_DIVU: begin
                w_res  = '1;
                w_div0 = 1'b1;
            end
            OP_REMU: begin
                w_res  = a;
                w_div0 = 1'b1;
            end
            default: w_res = '0;
        endcase
    end

    // Pick the iterative unit's result for the op in flight.
    always_comb begin
        w_it_res  = '0;
        w_it_ovfl = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_it_res  = w_prod_lo;
                w_it_ovfl = w_prod_hi_nz;
            end
            OP_DIVU: w_it_res = w_quot;
            OP_REMU: w_it_res = w_rem;
            default: w_it_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load       (w_go_calc),
        .op         (op),
        .a          (a),
        .b          (b),
        .prod_lo    (w_prod_lo),
        .prod_hi_nz (w_prod_hi_nz),
        .quot       (w_quot),
        .rem        (w_rem),
        .last       (w_last)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_go_calc) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers: result and flags only change together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_r    <= '0;
            r_zero <= 1'b0;
            r_ovfl <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_go_single) begin
                r_r    <= w_res;
                r_zero <= (w_res == '0);
                r_ovfl <= w_ovfl;
                r_div0 <= w_div0;
                r_done <= 1'b1;
            end else if (w_go_calc) begin
                r_op   <= op;
                r_busy <= 1'b1;
            end else if ((r_state == CALC) && w_last) begin
                r_r    <= w_it_res;
                r_zero <= (w_it_res == '0);
                r_ovfl <= w_it_ovfl;
                r_div0 <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign r    = r_r;
    assign zero = r_zero;
    assign ovfl = r_ovfl;
    assign div0 = r_div0;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expectations, a monitor
// pops and checks them whenever done is seen.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        busy;
    logic        done;
    logic [15:0] r;
    logic        zero;
    logic        ovfl;
    logic        div0;

    typedef struct {
        string       name;
        logic [15:0] r;
        logic        z;
        logic        o;
        logic        d;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .zero  (zero),
        .ovfl  (ovfl),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                chk({e.name, "_r"},    32'(r),    32'(e.r));
                chk({e.name, "_zero"}, 32'(zero), 32'(e.z));
                chk({e.name, "_ovfl"}, 32'(ovfl), 32'(e.o));
                chk({e.name, "_div0"}, 32'(div0), 32'(e.d));
                chk({e.name, "_lat"},  32'(cyc),  32'(e.due));
            end
        end
    end

    // Drive one start pulse (called at a negedge); optionally queue the expectation.
    task automatic issue(input string name, input logic [3:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic push, input logic [15:0] er,
                         input logic eo, input logic ed, input int lat);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        if (push) begin
            e.name = name;
            e.r    = er;
            e.z    = (er == 16'h0);
            e.o    = eo;
            e.d    = ed;
            e.due  = cyc + lat;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("rst_r",    32'(r),    32'h0);
        chk("rst_zero", 32'(zero), 32'h0);
        chk("rst_ovfl", 32'(ovfl), 32'h0);
        chk("rst_div0", 32'(div0), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // rst wins over a simultaneous start
        rst = 1'b1; start = 1'b1; op = 4'd3; a = 16'h1; b = 16'h1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_done", 32'(done), 32'h0);
        idle(1);

        // single-cycle ops issued back-to-back
        issue("add_ovf",  4'd3,  16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 1);
        issue("sub_zero", 4'd4,  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
        issue("slt",      4'd5,  16'h0003, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 1'b0, 1);
        issue("sll",      4'd6,  16'h0001, 16'h0013, 1'b1, 16'h0008, 1'b0, 1'b0, 1);
        issue("srl",      4'd7,  16'h8000, 16'h000F, 1'b1, 16'h0001, 1'b0, 1'b0, 1);
        issue("and",      4'd0,  16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1);
        issue("or",       4'd1,  16'hF0F0, 16'hFF00, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1);
        issue("nor",      4'd2,  16'hF0F0, 16'h0F00, 1'b1, 16'h000F, 1'b0, 1'b0, 1);
        issue("sub_ovf",  4'd4,  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1);
        issue("add_wrap", 4'd3,  16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
        issue("slt_ge",   4'd5,  16'hFFFF, 16'h0003, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
        issue("rsvd",     4'd12, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
        issue("divu_0",   4'd9,  16'h1234, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1);
        issue("remu_0",   4'd10, 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1, 1);
        idle(2);

        // MUL with busy window: high for 16 cycles, low when done appears
        issue("mul_ovf", 4'd8, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b1, 1'b0, 17);
        chk("mul_busy_1", 32'(busy), 32'h1);
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("mul_busy_%0d", k), 32'(busy), (k <= 16) ? 32'h1 : 32'h0);
        end
        idle(1);

        issue("mul",      4'd8,  16'h0012, 16'h0034, 1'b1, 16'h03A8, 1'b0, 1'b0, 17);
        idle(17);
        issue("mul_max",  4'd8,  16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 1'b0, 17);
        idle(17);
        issue("divu",     4'd9,  16'h0064, 16'h0007, 1'b1, 16'h000E, 1'b0, 1'b0, 17);
        idle(17);
        issue("remu",     4'd10, 16'h0064, 16'h0007, 1'b1, 16'h0002, 1'b0, 1'b0, 17);
        idle(17);
        issue("divu_max", 4'd9,  16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 17);
        idle(17);
        issue("remu_sm",  4'd10, 16'h0005, 16'h0009, 1'b1, 16'h0005, 1'b0, 1'b0, 17);
        idle(17);

        // start during CALC is ignored; only the MUL completes
        issue("mul_ign", 4'd8, 16'h0003, 16'h0004, 1'b1, 16'h000C, 1'b0, 1'b0, 17);
        idle(3);
        issue("add_ign", 4'd3, 16'h0001, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        idle(13);

        // reset mid-DIVU abandons it
        t0 = cyc;
        issue("divu_rst", 4'd9, 16'h0064, 16'h0007, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        idle(t0 + 8 - cyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_r",    32'(r),    32'h0);
        idle(20);
        issue("add_after", 4'd3, 16'h0002, 16'h0003, 1'b1, 16'h0005, 1'b0, 1'b0, 1);
        idle(2);

        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done, expected done at cycle %0d", e.name, e.due);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
